// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction-fetch sequencer
//
// Reads the current PC from the PC register and fetches the instruction from
// instruction memory over a req/ack handshake. The instruction is then held
// for the decode stage until decode accepts it. The sequencer also produces
// the single-cycle PCWr strobe that makes the PC register load NPC.
//
// A fetch loop is IDLE -> REQ -> HOLD -> IDLE. With a same-cycle ack and a
// same-cycle ready this takes three cycles per instruction.
//
// Parameters
//   ACK_TIMEOUT  cycles spent in REQ without imem_ack before the request is
//                abandoned (>= 2)
//   CNT_W        width of the timeout counter (2**CNT_W >= ACK_TIMEOUT)
//
// Ports
//   clk         in   1   clock, rising edge
//   rst         in   1   asynchronous reset, active low
//   pc          in   32  current PC from the PC register
//   flush       in   1   redirect: NPC holds a branch/jump target
//   imem_ack    in   1   memory read complete, imem_rdata valid
//   imem_rdata  in   32  memory read data
//   id_ready    in   1   decode accepts if_instr this cycle
//   imem_req    out  1   memory read request
//   imem_addr   out  32  memory read address
//   pc_wr       out  1   PCWr strobe to the PC register (one-cycle pulse)
//   if_instr    out  32  fetched instruction
//   if_pc       out  32  address of if_instr
//   if_valid    out  1   if_instr / if_pc valid
//   fetch_err   out  1   sticky ack-timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter int ACK_TIMEOUT = 256,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        flush,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        pc_wr,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Counter value on the last cycle in S_REQ before the request is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic              flush_pend;
    logic              flush_pend_nx;
    logic              imem_req_nx;
    logic [31:0]       imem_addr_nx;
    logic              pc_wr_want;
    logic              pc_wr_nx;
    logic [31:0]       if_instr_nx;
    logic [31:0]       if_pc_nx;
    logic              if_valid_nx;
    logic              fetch_err_nx;

    // State and output registers. Every output is registered. Reset is
    // asynchronous, so an outstanding request drops the moment rst goes low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            flush_pend <= 1'b0;
            imem_req   <= 1'b0;
            imem_addr  <= 32'd0;
            pc_wr      <= 1'b0;
            if_instr   <= 32'd0;
            if_pc      <= 32'd0;
            if_valid   <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            flush_pend <= flush_pend_nx;
            imem_req   <= imem_req_nx;
            imem_addr  <= imem_addr_nx;
            pc_wr      <= pc_wr_nx;
            if_instr   <= if_instr_nx;
            if_pc      <= if_pc_nx;
            if_valid   <= if_valid_nx;
            fetch_err  <= fetch_err_nx;
        end
    end

    // Next-state and next-output logic. Every register holds by default and
    // pc_wr is only requested here; the final strobe is shaped below.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        flush_pend_nx = flush_pend;
        imem_req_nx   = imem_req;
        imem_addr_nx  = imem_addr;
        pc_wr_want    = 1'b0;
        if_instr_nx   = if_instr;
        if_pc_nx      = if_pc;
        if_valid_nx   = if_valid;
        fetch_err_nx  = fetch_err;

        unique case (state)
            S_IDLE: begin
                if (flush) begin
                    // Redirect while idle: load the target, then fetch it.
                    pc_wr_want = 1'b1;
                end else if (pc_wr) begin
                    // The PC register loads NPC on this edge; sampling pc now
                    // would see the stale value, so wait one cycle.
                end else begin
                    imem_addr_nx = pc;
                    imem_req_nx  = 1'b1;
                    cnt_nx       = '0;
                    state_nx     = S_REQ;
                end
            end

            S_REQ: begin
                // A request is never withdrawn; a flush during the transaction
                // is remembered and applied when it finishes.
                if (flush) begin
                    flush_pend_nx = 1'b1;
                end

                if (imem_ack) begin
                    imem_req_nx = 1'b0;
                    pc_wr_want  = 1'b1;
                    if (flush || flush_pend) begin
                        // Wrong-path data: drop it and let PC take the target.
                        flush_pend_nx = 1'b0;
                        state_nx      = S_IDLE;
                    end else begin
                        if_instr_nx = imem_rdata;
                        if_pc_nx    = imem_addr;
                        if_valid_nx = 1'b1;
                        state_nx    = S_HOLD;
                    end
                end else if (cnt == CNT_LAST) begin
                    // Memory never answered. Without a pending redirect PC is
                    // left alone so the same address is fetched again.
                    imem_req_nx   = 1'b0;
                    fetch_err_nx  = 1'b1;
                    pc_wr_want    = flush || flush_pend;
                    flush_pend_nx = 1'b0;
                    state_nx      = S_IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            S_HOLD: begin
                // Flush wins over id_ready: the held instruction is wrong-path.
                if (flush) begin
                    if_valid_nx = 1'b0;
                    pc_wr_want  = 1'b1;
                    state_nx    = S_IDLE;
                end else if (id_ready) begin
                    if_valid_nx = 1'b0;
                    state_nx    = S_IDLE;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // pc_wr is a single-cycle pulse. A second request arriving while the
    // strobe is already high is merged with it: the PC register is loading
    // NPC on that same edge, and a flush means NPC already holds the target.
    always_comb begin
        pc_wr_nx = pc_wr_want & ~pc_wr;
    end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- self-checking bench for if_fetch
//
// The bench plays the PC register (loads NPC on pc_wr; NPC is pc+4 unless a
// redirect target is pending), the instruction memory (a fixed function of
// the address, answering after a programmable latency) and the decode stage.
// Directed steps cover reset, single fetch, back-to-back fetch, backpressure,
// flush and timeout; a randomized phase then checks the delivered
// instruction stream against program order.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    localparam int TIMEOUT = 6;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        flush;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        pc_wr;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        fetch_err;

    int          checks;
    int          errors;
    int          pc_wr_count;
    int          delivered;
    int          snap;
    logic [31:0] exp_pc;
    logic        redirect;
    logic [31:0] target;
    logic        ack_enable;
    logic        rand_lat;
    int          ack_delay;
    int          req_age;
    logic        sb_enable;

    if_fetch #(
        .ACK_TIMEOUT (TIMEOUT),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .flush      (flush),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_ready   (id_ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .pc_wr      (pc_wr),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_valid   (if_valid),
        .fetch_err  (fetch_err)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: one fixed word at 0x3000, a simple address hash elsewhere.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2408_0005;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic rdy, input logic fl);
        id_ready = rdy;
        flush    = fl;
    endtask

    // Advance one clock edge and update the environment models.
    task automatic tick();
        logic        valid_pre, ready_pre, flush_pre, req_pre, wr_pre, ack_pre;
        logic [31:0] instr_pre, ifpc_pre, addr_pre, pc_pre;
        valid_pre = if_valid;
        ready_pre = id_ready;
        flush_pre = flush;
        req_pre   = imem_req;
        wr_pre    = pc_wr;
        ack_pre   = imem_ack;
        instr_pre = if_instr;
        ifpc_pre  = if_pc;
        addr_pre  = imem_addr;
        pc_pre    = pc;
        @(posedge clk);
        #1;
        // PC register: loads NPC on the edge where pc_wr was high.
        if (wr_pre) begin
            pc       = redirect ? target : pc + 32'd4;
            redirect = 1'b0;
        end
        if (pc_wr) pc_wr_count++;
        if (sb_enable) begin
            if (valid_pre && ready_pre && !flush_pre) begin
                check_output("deliver_pc", ifpc_pre, exp_pc);
                check_output("deliver_instr", instr_pre, mem_fn(exp_pc));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            check_output("pc_wr_not_back_to_back", {31'd0, wr_pre & pc_wr}, 32'd0);
            if (!req_pre && imem_req)
                check_output("req_addr_is_pc", imem_addr, pc_pre);
            if (req_pre && !ack_pre)
                check_output("req_held_until_ack", {31'd0, imem_req}, 32'd1);
            if (req_pre && !ack_pre && imem_req)
                check_output("addr_stable", imem_addr, addr_pre);
        end
        // Memory responder: one-cycle ack after ack_delay waiting cycles.
        if (imem_ack) begin
            imem_ack = 1'b0;
            req_age  = 0;
        end else if (imem_req && ack_enable) begin
            if (req_age >= ack_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_fn(imem_addr);
                req_age    = 0;
                if (rand_lat) ack_delay = $urandom_range(0, 3);
            end else begin
                req_age++;
            end
        end else begin
            req_age = 0;
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        pc_wr_count = 0;
        delivered   = 0;
        exp_pc      = 32'd0;
        redirect    = 1'b0;
        target      = 32'd0;
        ack_enable  = 1'b0;
        rand_lat    = 1'b0;
        ack_delay   = 0;
        req_age     = 0;
        sb_enable   = 1'b0;
        rst         = 1'b0;
        pc          = 32'h0000_3000;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        apply_stimulus(1'b0, 1'b0);

        // T1: reset values, then an asynchronous reset in the middle of S_REQ.
        tick();
        tick();
        check_output("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check_output("rst_imem_addr", imem_addr, 32'd0);
        check_output("rst_pc_wr", {31'd0, pc_wr}, 32'd0);
        check_output("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check_output("rst_if_instr", if_instr, 32'd0);
        check_output("rst_if_pc", if_pc, 32'd0);
        check_output("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
        #4 rst = 1'b1;
        tick();
        check_output("t1_first_req", {31'd0, imem_req}, 32'd1);
        check_output("t1_first_addr", imem_addr, 32'h0000_3000);
        tick();
        #2 rst = 1'b0;
        #1;
        check_output("t1_async_req", {31'd0, imem_req}, 32'd0);
        check_output("t1_async_addr", imem_addr, 32'd0);
        check_output("t1_async_valid", {31'd0, if_valid}, 32'd0);
        #2 rst = 1'b1;
        ack_enable = 1'b1;
        ack_delay  = 0;
        tick();
        check_output("t1_rerelease_req", {31'd0, imem_req}, 32'd1);
        check_output("t1_rerelease_addr", imem_addr, 32'h0000_3000);

        // T2: single fetch with an immediate ack.
        tick();
        check_output("t2_valid", {31'd0, if_valid}, 32'd1);
        check_output("t2_instr", if_instr, 32'h2408_0005);
        check_output("t2_if_pc", if_pc, 32'h0000_3000);
        check_output("t2_pc_wr", {31'd0, pc_wr}, 32'd1);
        check_output("t2_req_low", {31'd0, imem_req}, 32'd0);
        tick();
        check_output("t2_pc_wr_pulse", {31'd0, pc_wr}, 32'd0);

        // T4: decode stalls for 10 cycles; the held instruction must not move.
        for (int i = 0; i < 10; i++) begin
            tick();
            check_output("t4_valid", {31'd0, if_valid}, 32'd1);
            check_output("t4_instr", if_instr, 32'h2408_0005);
            check_output("t4_no_req", {31'd0, imem_req}, 32'd0);
            check_output("t4_no_pc_wr", {31'd0, pc_wr}, 32'd0);
        end

        // T3: back-to-back fetches, one every three cycles.
        apply_stimulus(1'b1, 1'b0);
        snap = pc_wr_count;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output("t3_idle_valid", {31'd0, if_valid}, 32'd0);
            tick();
            check_output("t3_req", {31'd0, imem_req}, 32'd1);
            check_output("t3_addr", imem_addr, 32'h0000_3004 + 32'(4 * k));
            tick();
            check_output("t3_valid", {31'd0, if_valid}, 32'd1);
            check_output("t3_if_pc", if_pc, 32'h0000_3004 + 32'(4 * k));
            check_output("t3_instr", if_instr, mem_fn(32'h0000_3004 + 32'(4 * k)));
        end
        check_output("t3_pc_wr_count", 32'(pc_wr_count - snap), 32'd3);

        // T5a: flush during S_REQ, ack four cycles later.
        ack_enable = 1'b0;
        tick();
        apply_stimulus(1'b0, 1'b0);
        tick();
        check_output("t5_req_addr", imem_addr, 32'h0000_3010);
        snap = pc_wr_count;
        apply_stimulus(1'b0, 1'b1);
        redirect = 1'b1;
        target   = 32'h0000_3100;
        tick();
        apply_stimulus(1'b0, 1'b0);
        check_output("t5_req_after_flush", {31'd0, imem_req}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("t5_req_stable", {31'd0, imem_req}, 32'd1);
            check_output("t5_addr_stable", imem_addr, 32'h0000_3010);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        check_output("t5_discard_valid", {31'd0, if_valid}, 32'd0);
        check_output("t5_discard_pc_wr", {31'd0, pc_wr}, 32'd1);
        check_output("t5_discard_req", {31'd0, imem_req}, 32'd0);
        ack_enable = 1'b1;
        ack_delay  = 0;
        tick();
        check_output("t5_wait_req", {31'd0, imem_req}, 32'd0);
        check_output("t5_wait_pc_wr", {31'd0, pc_wr}, 32'd0);
        tick();
        check_output("t5_target_req", {31'd0, imem_req}, 32'd1);
        check_output("t5_target_addr", imem_addr, 32'h0000_3100);
        check_output("t5_pc_wr_count", 32'(pc_wr_count - snap), 32'd1);

        // T5b: flush together with id_ready while holding an instruction.
        tick();
        check_output("t5b_valid", {31'd0, if_valid}, 32'd1);
        check_output("t5b_if_pc", if_pc, 32'h0000_3100);
        tick();
        apply_stimulus(1'b1, 1'b1);
        redirect = 1'b1;
        target   = 32'h0000_3200;
        ack_enable = 1'b0;
        tick();
        apply_stimulus(1'b1, 1'b0);
        check_output("t5b_dropped", {31'd0, if_valid}, 32'd0);
        check_output("t5b_pc_wr", {31'd0, pc_wr}, 32'd1);
        tick();
        tick();
        check_output("t5b_target_addr", imem_addr, 32'h0000_3200);
        check_output("t5b_err_clear", {31'd0, fetch_err}, 32'd0);

        // T6: no ack; request abandoned after TIMEOUT cycles, then retried.
        snap = pc_wr_count;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            check_output("t6_req_waiting", {31'd0, imem_req}, 32'd1);
        end
        ack_enable = 1'b1;
        tick();
        check_output("t6_req_dropped", {31'd0, imem_req}, 32'd0);
        check_output("t6_fetch_err", {31'd0, fetch_err}, 32'd1);
        check_output("t6_no_pc_wr", {31'd0, pc_wr}, 32'd0);
        tick();
        check_output("t6_retry_req", {31'd0, imem_req}, 32'd1);
        check_output("t6_retry_addr", imem_addr, 32'h0000_3200);
        tick();
        check_output("t6_retry_if_pc", if_pc, 32'h0000_3200);
        check_output("t6_err_sticky", {31'd0, fetch_err}, 32'd1);
        check_output("t6_pc_wr_count", 32'(pc_wr_count - snap), 32'd1);

        // Randomized phase: random memory latency and decode backpressure.
        rst = 1'b0;
        #2;
        check_output("rand_err_cleared", {31'd0, fetch_err}, 32'd0);
        imem_ack   = 1'b0;
        pc         = 32'h0000_4000;
        redirect   = 1'b0;
        exp_pc     = 32'h0000_4000;
        rand_lat   = 1'b1;
        ack_delay  = $urandom_range(0, 3);
        req_age    = 0;
        delivered  = 0;
        apply_stimulus(1'b0, 1'b0);
        #2 rst = 1'b1;
        snap      = pc_wr_count;
        sb_enable = 1'b1;
        for (int i = 0; i < 400; i++) begin
            id_ready = 1'($urandom_range(0, 1));
            tick();
        end
        sb_enable = 1'b0;
        check_output("rand_enough_fetches", {31'd0, delivered >= 10}, 32'd1);
        check_output("rand_pc_wr_per_fetch", 32'(pc_wr_count - snap),
                     32'(delivered + (if_valid ? 1 : 0)));
        check_output("rand_no_err", {31'd0, fetch_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
